// File: rtl/pim_pkg.sv
// ------------------------------------------------------------------------
// pim_pkg: shared types and helpers for the PIM input splitter. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package pim_pkg;

  localparam int DATA_WIDTH_INPUT = 8;
  localparam int LANE_W           = DATA_WIDTH_INPUT + 1;
  localparam int MAX_W            = 31;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Returns {sat, magnitude}; magnitude clamps to 2^w-1 when |x| needs w+1 bits.
  function automatic logic [MAX_W:0] sat_abs(input logic [MAX_W:0] x, input int unsigned w);
    logic [MAX_W:0] mag;
    logic [MAX_W:0] lim;
    logic           sat;
    mag = x[MAX_W] ? (~x + (MAX_W+1)'(1)) : x;
    lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
    sat = (mag > lim);
    if (sat) begin
      mag = lim;
    end
    return {sat, mag[MAX_W-1:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pim_lane_serializer.sv
// ------------------------------------------------------------------------
// pim_lane_serializer: one lane's pos/neg magnitude split and shifters. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module pim_lane_serializer
  import pim_pkg::*;
#(
  parameter int W = DATA_WIDTH_INPUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W:0]   lane_in,
  output logic         pos_bit,
  output logic         neg_bit,
  output logic         sat_flag
);

  logic [MAX_W:0] lane_ext;
  logic [MAX_W:0] abs_res;
  logic [W-1:0]   pos_d, pos_q;
  logic [W-1:0]   neg_d, neg_q;
  logic           sat_d, sat_q;
  logic           unused_abs;

  assign unused_abs = ^abs_res[MAX_W-1:W];

  always_comb begin
    lane_ext = {{(MAX_W-W){lane_in[W]}}, lane_in};
    abs_res  = sat_abs(lane_ext, W);
    pos_d    = pos_q;
    neg_d    = neg_q;
    sat_d    = sat_q;
    // A load on the final beat must win over the shift of the old vector.
    if (load) begin
      sat_d = abs_res[MAX_W];
      if (lane_in[W]) begin
        pos_d = '0;
        neg_d = abs_res[W-1:0];
      end else begin
        pos_d = lane_in[W-1:0];
        neg_d = '0;
      end
    end else if (shift) begin
      pos_d = pos_q >> 1;
      neg_d = neg_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      neg_q <= '0;
      sat_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      neg_q <= neg_d;
      sat_q <= sat_d;
    end
  end

  assign pos_bit  = pos_q[0];
  assign neg_bit  = neg_q[0];
  assign sat_flag = sat_q;

endmodule

`default_nettype wire

// File: rtl/pim_input_splitter.sv
// ------------------------------------------------------------------------
// pim_input_splitter: signed vector to bit-serial pos/neg magnitude planes. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module pim_input_splitter
  import pim_pkg::*;
#(
  parameter int Data_width_input = 8,
  parameter int N_lanes          = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [N_lanes*(Data_width_input+1)-1:0] in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [N_lanes-1:0]                      pos_bit,
  output logic [N_lanes-1:0]                      neg_bit,
  output logic [$clog2(Data_width_input)-1:0]     bit_idx,
  output logic                                    bit_last,
  output logic [N_lanes-1:0]                      sat_flag
);

  localparam int W     = Data_width_input;
  localparam int LW    = W + 1;
  localparam int IDX_W = $clog2(W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

  state_t           state_d, state_q;
  logic [IDX_W-1:0] bit_idx_d, bit_idx_q;
  logic             beat;
  logic             accept;

  always_comb begin
    out_valid = (state_q == SHIFT);
    bit_last  = out_valid && (bit_idx_q == LAST_IDX);
    beat      = out_valid && out_ready;
    // Gating with rst keeps the reset cycle from looking like an accept slot.
    in_ready  = !rst && ((state_q == IDLE) || (beat && bit_last));
    accept    = in_valid && in_ready;
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SHIFT;
          bit_idx_d = '0;
        end
      end
      SHIFT: begin
        if (beat) begin
          if (bit_last) begin
            state_d   = accept ? SHIFT : IDLE;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  assign bit_idx = bit_idx_q;

  for (genvar k = 0; k < N_lanes; k++) begin : g_lane
    pim_lane_serializer #(
      .W (W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .shift    (beat),
      .lane_in  (in_data[k*LW +: LW]),
      .pos_bit  (pos_bit[k]),
      .neg_bit  (neg_bit[k]),
      .sat_flag (sat_flag[k])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_pim_input_splitter.sv
// ------------------------------------------------------------------------
// tb_pim_input_splitter: directed bench for pim_input_splitter (W=8, 4 lanes). Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_pim_input_splitter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int LW = W + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N*LW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    pos_bit;
  logic [N-1:0]    neg_bit;
  logic [2:0]      bit_idx;
  logic            bit_last;
  logic [N-1:0]    sat_flag;

  int checks   = 0;
  int failures = 0;

  int           got_pos [N];
  int           got_neg [N];
  logic [N-1:0] got_sat;
  int           got_beats;
  logic         idx_ok, orth_ok, last_ok, sat_ok;

  pim_input_splitter #(
    .Data_width_input (W),
    .N_lanes          (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pos_bit   (pos_bit),
    .neg_bit   (neg_bit),
    .bit_idx   (bit_idx),
    .bit_last  (bit_last),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*LW-1:0] pack(input int a, input int b, input int c, input int d);
    logic [N*LW-1:0] r;
    r[0*LW +: LW] = a[LW-1:0];
    r[1*LW +: LW] = b[LW-1:0];
    r[2*LW +: LW] = c[LW-1:0];
    r[3*LW +: LW] = d[LW-1:0];
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [N*LW-1:0] d, input string tag);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '1;
  endtask

  task automatic collect(input int stall_at, input string tag);
    logic [31:0] snap;
    for (int k = 0; k < N; k++) begin
      got_pos[k] = 0;
      got_neg[k] = 0;
    end
    got_beats = 0;
    got_sat   = '0;
    idx_ok    = 1'b1;
    orth_ok   = 1'b1;
    last_ok   = 1'b1;
    sat_ok    = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && got_beats < W; cyc++) begin
      if (out_valid) begin
        if (int'(bit_idx) != got_beats) idx_ok = 1'b0;
        if ((pos_bit & neg_bit) != '0) orth_ok = 1'b0;
        if (bit_last != (got_beats == W - 1)) last_ok = 1'b0;
        if (got_beats == 0) got_sat = sat_flag;
        else if (sat_flag != got_sat) sat_ok = 1'b0;
        if (got_beats == stall_at) begin
          snap      = {15'd0, out_valid, bit_last, bit_idx, sat_flag, neg_bit, pos_bit};
          out_ready = 1'b0;
          for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check({tag, "_stall_hold"},
                  {15'd0, out_valid, bit_last, bit_idx, sat_flag, neg_bit, pos_bit}, snap);
            check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
          end
          out_ready = 1'b1;
        end
        for (int k = 0; k < N; k++) begin
          got_pos[k] = got_pos[k] | (int'(pos_bit[k]) << got_beats);
          got_neg[k] = got_neg[k] | (int'(neg_bit[k]) << got_beats);
        end
        got_beats++;
      end
      @(negedge clk);
    end
    check({tag, "_beats"}, 32'(got_beats), 32'(W));
    check({tag, "_idx_seq"}, 32'(idx_ok), 32'd1);
    check({tag, "_pos_and_neg_zero"}, 32'(orth_ok), 32'd1);
    check({tag, "_bit_last_pos"}, 32'(last_ok), 32'd1);
    check({tag, "_sat_stable"}, 32'(sat_ok), 32'd1);
  endtask

  initial begin
    int           v [N];
    int           a_pos [N];
    int           a_neg [N];
    int           b_pos [N];
    int           b_neg [N];
    logic [N-1:0] a_sat, b_sat;
    logic         gap_ok, idx2_ok, early_ok;
    int           guard;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_pos_bit", 32'(pos_bit), 32'd0);
    check("rst_neg_bit", 32'(neg_bit), 32'd0);
    check("rst_bit_idx", 32'(bit_idx), 32'd0);
    check("rst_bit_last", 32'(bit_last), 32'd0);
    check("rst_sat_flag", 32'(sat_flag), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic split {+5, -3, 0, +255}
    send(pack(5, -3, 0, 255), "basic");
    collect(-1, "basic");
    check("basic_pos0", got_pos[0], 5);
    check("basic_pos1", got_pos[1], 0);
    check("basic_pos2", got_pos[2], 0);
    check("basic_pos3", got_pos[3], 255);
    check("basic_neg0", got_neg[0], 0);
    check("basic_neg1", got_neg[1], 3);
    check("basic_neg2", got_neg[2], 0);
    check("basic_neg3", got_neg[3], 0);
    check("basic_sat", 32'(got_sat), 32'h0);
    check("basic_idle_after", 32'(out_valid), 32'd0);

    // Saturation {-256, -1, 7, -128}
    send(pack(-256, -1, 7, -128), "sat");
    collect(-1, "sat");
    check("sat_neg0", got_neg[0], 255);
    check("sat_pos0", got_pos[0], 0);
    check("sat_neg1", got_neg[1], 1);
    check("sat_pos2", got_pos[2], 7);
    check("sat_neg3", got_neg[3], 128);
    check("sat_flags", 32'(got_sat), 32'h1);

    // Back-to-back: A = {1, -2, 100, -256}, B = {-100, 3, -255, 0}
    in_valid = 1'b1;
    in_data  = pack(1, -2, 100, -256);
    #1;
    check("b2b_a_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_data  = pack(-100, 3, -255, 0);
    out_ready = 1'b1;
    gap_ok   = 1'b1;
    idx2_ok  = 1'b1;
    early_ok = 1'b1;
    a_sat    = '0;
    b_sat    = '0;
    for (int k = 0; k < N; k++) begin
      a_pos[k] = 0; a_neg[k] = 0; b_pos[k] = 0; b_neg[k] = 0;
    end
    for (int i = 0; i < 16; i++) begin
      if (!out_valid) gap_ok = 1'b0;
      if (int'(bit_idx) != (i % 8)) idx2_ok = 1'b0;
      if (i == 7) begin
        check("b2b_last_in_ready", 32'(in_ready), 32'd1);
        check("b2b_last_bit_last", 32'(bit_last), 32'd1);
      end else if (i < 7 && in_ready) begin
        early_ok = 1'b0;
      end
      if (i == 8) begin
        in_valid = 1'b0;
        in_data  = '1;
      end
      for (int k = 0; k < N; k++) begin
        if (i < 8) begin
          a_pos[k] = a_pos[k] | (int'(pos_bit[k]) << i);
          a_neg[k] = a_neg[k] | (int'(neg_bit[k]) << i);
        end else begin
          b_pos[k] = b_pos[k] | (int'(pos_bit[k]) << (i - 8));
          b_neg[k] = b_neg[k] | (int'(neg_bit[k]) << (i - 8));
        end
      end
      if (i == 0) a_sat = sat_flag;
      if (i == 8) b_sat = sat_flag;
      @(negedge clk);
    end
    check("b2b_no_gap", 32'(gap_ok), 32'd1);
    check("b2b_idx_seq", 32'(idx2_ok), 32'd1);
    check("b2b_no_early_ready", 32'(early_ok), 32'd1);
    check("b2b_idle_after", 32'(out_valid), 32'd0);
    check("b2b_a_pos0", a_pos[0], 1);
    check("b2b_a_neg1", a_neg[1], 2);
    check("b2b_a_pos2", a_pos[2], 100);
    check("b2b_a_neg3", a_neg[3], 255);
    check("b2b_a_sat", 32'(a_sat), 32'h8);
    check("b2b_b_neg0", b_neg[0], 100);
    check("b2b_b_pos1", b_pos[1], 3);
    check("b2b_b_neg2", b_neg[2], 255);
    check("b2b_b_pos3", b_pos[3], 0);
    check("b2b_b_neg3", b_neg[3], 0);
    check("b2b_b_sat", 32'(b_sat), 32'h0);

    // Backpressure at bit 4: {200, -77, -256, 1}
    send(pack(200, -77, -256, 1), "bp");
    collect(4, "bp");
    check("bp_pos0", got_pos[0], 200);
    check("bp_neg1", got_neg[1], 77);
    check("bp_neg2", got_neg[2], 255);
    check("bp_pos3", got_pos[3], 1);
    check("bp_sat", 32'(got_sat), 32'h4);

    // Reset mid-stream at bit 3
    send(pack(-256, 9, -9, 0), "rstm");
    out_ready = 1'b1;
    guard     = 0;
    while (bit_idx != 3'd3 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("rstm_reached_idx3", 32'(bit_idx), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("rstm_out_valid", 32'(out_valid), 32'd0);
    check("rstm_bit_idx", 32'(bit_idx), 32'd0);
    check("rstm_sat_flag", 32'(sat_flag), 32'd0);
    check("rstm_bit_last", 32'(bit_last), 32'd0);
    check("rstm_in_ready_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstm_in_ready_after", 32'(in_ready), 32'd1);
    send(pack(-17, 64, 0, -256), "fresh");
    collect(-1, "fresh");
    check("fresh_neg0", got_neg[0], 17);
    check("fresh_pos1", got_pos[1], 64);
    check("fresh_pos2", got_pos[2], 0);
    check("fresh_neg3", got_neg[3], 255);
    check("fresh_sat", 32'(got_sat), 32'h8);

    // Recombination: pos - neg restores x, except -256 -> -255
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < N; k++) v[k] = int'($urandom_range(0, 511)) - 256;
      if (t == 0) v[0] = -256;
      send(pack(v[0], v[1], v[2], v[3]), "recomb");
      collect(-1, "recomb");
      for (int k = 0; k < N; k++) begin
        check("recomb_value", got_pos[k] - got_neg[k], (v[k] == -256) ? -255 : v[k]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pim_input_splitter.md
# pim_input_splitter

Front-end streaming block for the PIM macro. It accepts a vector of signed two's-complement activations and splits each lane into a positive-magnitude plane and a negative-magnitude plane. It then streams both planes bit-serially, LSB first, into the positive and negative PIM arrays. It is the inverse of the final pos/neg magnitude recombination stage at the array output; that stage reconstructs a signed result from the two accumulated magnitudes.

## Interface

Parameters:

- `Data_width_input`, default 8: magnitude bits per lane. Each lane input is `Data_width_input+1` bits, two's complement.
- `N_lanes`, default 4: number of activation lanes presented per vector.

Ports:

- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: input vector valid.
- `in_ready` output 1: block can accept a vector this cycle.
- `in_data` input `N_lanes*(Data_width_input+1)`: lane k occupies bits `[k*(W+1) +: W+1]`, where W = `Data_width_input`.
- `out_valid` output 1: bit-plane outputs valid.
- `out_ready` input 1: downstream array consumes the current bit-plane.
- `pos_bit` output `N_lanes`: current bit of each lane's positive magnitude.
- `neg_bit` output `N_lanes`: current bit of each lane's negative magnitude.
- `bit_idx` output `$clog2(W)`: index of the current bit, 0 to W-1.
- `bit_last` output 1: high when `bit_idx == W-1`.
- `sat_flag` output `N_lanes`: per lane, high for the whole vector if that lane was saturated. Held constant across all bits of the vector.

## Operation

- FSM has two states, IDLE and SHIFT.
- Accept occurs when `in_valid && in_ready`. Per lane x:
  - x ≥ 0: pos magnitude = x[W-1:0], neg magnitude = 0.
  - x < 0: pos magnitude = 0, neg magnitude = -x.
  - x = -2^W (e.g. -256 for W=8): neg magnitude saturates to 2^W-1 and that lane's `sat_flag` is set.
  - x = 0: both magnitudes are 0 and `sat_flag` is 0.
- Magnitudes are loaded into per-lane W-bit shift registers, one positive and one negative. `pos_bit`/`neg_bit` equal the register LSBs.
- In SHIFT, `out_valid` is 1. On `out_valid && out_ready`:
  - both registers shift right by one;
  - `bit_idx` increments.
- On the handshake with `bit_last`:
  - if `in_valid` is also high, the new vector loads and SHIFT continues at `bit_idx` 0;
  - otherwise the FSM goes to IDLE.
- `in_ready = (state==IDLE) || (out_valid && out_ready && bit_last)`. This gives a back-to-back throughput of one vector per W cycles.
- Stall: while `out_ready` is 0, all outputs hold exactly. `in_ready` is 0 during SHIFT except on the final accepted bit.
- Invariant: for every lane and every bit, `pos_bit & neg_bit == 0`.

## Timing

- Reset values:
  - state = IDLE;
  - `in_ready`, `out_valid`, `pos_bit`, `neg_bit`, `bit_idx`, `bit_last`, `sat_flag` are all 0;
  - shift registers are cleared.
- `in_ready` is 0 during the reset cycle and 1 from the first cycle after `rst` deasserts.
- Latency: a vector accepted in cycle t presents bit 0 with `out_valid=1` in cycle t+1.
- Stream length: exactly W accepted beats per vector.
- `rst` asserted mid-stream takes priority over any handshake in that cycle. The vector in flight is discarded with no partial completion and no `bit_last`.
- `bit_idx` never wraps past W-1; the load on the last beat resets it to 0.
- `in_data` is sampled only on the accept cycle. Later changes to it have no effect.

## Structure

- Shared package `pim_pkg`:
  - lane-width localparam `LANE_W = Data_width_input+1`;
  - FSM state enum with states IDLE and SHIFT;
  - function `sat_abs` returning {sat, magnitude} from a signed lane value.
- One sub-module, `pim_lane_serializer`: per-lane magnitude split, saturation and the pos/neg shift registers. It is instantiated `N_lanes` times under a generate loop.
- The top level holds the FSM, the `bit_idx` counter and the handshake logic.

## Test plan

All scenarios use W=8 and N_lanes=4.

- **Basic split.** Lanes {+5, -3, 0, +255}, `out_ready` held 1.
  - Required: 8 beats, `bit_last` on beat 7, `sat_flag`=0000.
  - `pos` LSB-first reconstructs {5, 0, 0, 255}; `neg` reconstructs {0, 3, 0, 0}.
- **Saturation.** Lane0 = -256, lane1 = -1.
  - Required: neg lane0 = 255 with `sat_flag[0]`=1; neg lane1 = 1 with `sat_flag[1]`=0.
  - `pos_bit & neg_bit` is 0 on every beat.
- **Back-to-back.** `in_valid` held high with two vectors, `out_ready`=1.
  - Required: the second vector is accepted in the same cycle as the first vector's `bit_last`.
  - Its bit 0 appears the next cycle, for 16 consecutive `out_valid` beats with no gap.
- **Backpressure.** `out_ready` is 0 for 3 cycles at `bit_idx`=4.
  - Required: all outputs hold stable for those 3 cycles and `in_ready` stays 0.
  - Streaming resumes at `bit_idx`=4 with no lost or duplicated bit.
- **Reset mid-stream.** Assert `rst` at `bit_idx`=3.
  - Required: next cycle `out_valid`=0, `bit_idx`=0, `sat_flag`=0.
  - `in_ready` is 1 one cycle after `rst` drops, and a fresh vector streams correctly.
- **Recombination check.** Random signed lanes.
  - Required: feed the pos and neg reconstructed magnitudes through the array-output recombination stage; the result equals the original value for every input except -256, where it is -255.
